// File: rtl/iq_capture_dbg_pkg.sv
// iq_capture_dbg_pkg: shared types and widths for the iq_capture deadlock reporting path
package iq_capture_dbg_pkg;
  typedef enum logic [1:0] {IDLE, REPORT, HOLD} dl_state_e;
  localparam int DL_COUNT_W = 16;
  localparam int DL_MON_IDX_W = 4;
  typedef struct packed {
    logic [31:0] ts;
    logic [DL_MON_IDX_W-1:0] mon;
    logic [15:0] info;
  } dl_report_t;
endpackage

// File: rtl/iq_capture_prio_sel.sv
// iq_capture_prio_sel: lowest-index blocked monitor and its axis_block_info slice
module iq_capture_prio_sel
  import iq_capture_dbg_pkg::*;
#(
  parameter int NUM_MON = 1,
  parameter int INFO_W = 1
) (
  input  logic [NUM_MON-1:0]        block,
  input  logic [NUM_MON*INFO_W-1:0] info,
  output logic [DL_MON_IDX_W-1:0]   idx,
  output logic [INFO_W-1:0]         sel_info
);
  // scan high to low so the lowest asserted index is the last to win
  always_comb begin
    idx = '0;
    sel_info = '0;
    for (int i = NUM_MON - 1; i >= 0; i--)
      if (block[i]) begin
        idx = DL_MON_IDX_W'(i);
        sel_info = info[i*INFO_W +: INFO_W];
      end
  end
endmodule

// File: rtl/iq_capture_deadlock_reporter.sv
// iq_capture_deadlock_reporter: persistence-filtered, timestamped deadlock reports with sticky flag and counter
module iq_capture_deadlock_reporter
  import iq_capture_dbg_pkg::*;
#(
  parameter int NUM_MON = 1,
  parameter int INFO_W = 1,
  parameter int PERSIST = 16,
  parameter int TS_W = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_MON-1:0]          block_in,
  input  logic [NUM_MON*INFO_W-1:0]   axis_info_in,
  input  logic                        clear,
  output logic                        rpt_valid,
  input  logic                        rpt_ready,
  output logic [TS_W-1:0]             rpt_ts,
  output logic [DL_MON_IDX_W-1:0]     rpt_mon,
  output logic [INFO_W-1:0]           rpt_info,
  output logic                        deadlock_sticky,
  output logic [DL_COUNT_W-1:0]       deadlock_count
);
  localparam int PCW = $clog2(PERSIST + 1);
  dl_state_e state, state_nx;
  logic [TS_W-1:0] ts_q;
  logic [PCW-1:0] pcnt;
  logic any_blk, confirm, hs;
  logic [DL_MON_IDX_W-1:0] sel_mon;
  logic [INFO_W-1:0] sel_info;
  assign any_blk = |block_in;
  assign confirm = state == IDLE && any_blk && pcnt == PCW'(PERSIST - 1);
  assign hs = state == REPORT && rpt_ready;
  assign rpt_valid = state == REPORT;
  iq_capture_prio_sel #(.NUM_MON(NUM_MON), .INFO_W(INFO_W)) u_sel (
    .block(block_in),
    .info(axis_info_in),
    .idx(sel_mon),
    .sel_info(sel_info)
  );
  // clear overrides everything; HOLD waits for one unblocked cycle so a single stall reports once
  always_comb
    state_nx = clear ? IDLE : confirm ? REPORT : hs ? HOLD : (state == HOLD && !any_blk) ? IDLE : state;
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nx;
  // free-running timestamp, untouched by clear
  always_ff @(posedge clock)
    ts_q <= reset ? '0 : ts_q + TS_W'(1);
  // consecutive blocked cycles, counted only while armed in IDLE
  always_ff @(posedge clock)
    pcnt <= (reset || clear || state != IDLE || !any_blk || confirm) ? '0 : pcnt + PCW'(1);
  // capture report and update sticky/count; clear beats a coincident confirmation
  always_ff @(posedge clock)
    if (reset) begin
      rpt_ts <= '0;
      rpt_mon <= '0;
      rpt_info <= '0;
      deadlock_sticky <= 1'b0;
      deadlock_count <= '0;
    end else if (clear) begin
      deadlock_sticky <= 1'b0;
      deadlock_count <= '0;
    end else if (confirm) begin
      rpt_ts <= ts_q;
      rpt_mon <= sel_mon;
      rpt_info <= sel_info;
      deadlock_sticky <= 1'b1;
      deadlock_count <= (&deadlock_count) ? deadlock_count : deadlock_count + DL_COUNT_W'(1);
    end
endmodule

// File: tb/tb_iq_capture_deadlock_reporter.sv
// tb_iq_capture_deadlock_reporter: directed scoreboard bench for the deadlock reporter
module tb_iq_capture_deadlock_reporter;
  localparam int P = 4;
  logic clock = 0, reset = 1, clear = 0, rpt_ready = 0;
  logic [1:0] block_in = '0, axis_info_in = '0;
  logic rpt_valid, rpt_info, sticky;
  logic [31:0] rpt_ts;
  logic [3:0] rpt_mon;
  logic [15:0] count;
  int cyc = 0, vecs = 0, errs = 0, exp_cnt = 0;
  typedef struct {logic [31:0] ts; logic [3:0] mon; logic info;} exp_t;
  exp_t q[$];
  exp_t last;

  iq_capture_deadlock_reporter #(.NUM_MON(2), .INFO_W(1), .PERSIST(P), .TS_W(32)) dut (
    .clock(clock), .reset(reset), .block_in(block_in), .axis_info_in(axis_info_in),
    .clear(clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_ts(rpt_ts),
    .rpt_mon(rpt_mon), .rpt_info(rpt_info), .deadlock_sticky(sticky), .deadlock_count(count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [1:0] b, logic [1:0] inf, int at);
    exp_t e;
    e.ts = at;
    e.mon = b[0] ? 4'd0 : 4'd1;
    e.info = b[0] ? inf[0] : inf[1];
    q.push_back(e);
    exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
  endtask

  task automatic pop_check(string tag);
    exp_t e;
    if (q.size() == 0) begin
      vecs++;
      errs++;
      $error("FAIL %s: report observed with empty scoreboard", tag);
    end else begin
      e = q.pop_front();
      last = e;
      chk({tag, "_ts"}, rpt_ts, e.ts);
      chk({tag, "_mon"}, rpt_mon, e.mon);
      chk({tag, "_info"}, rpt_info, e.info);
    end
  endtask

  task automatic event_go(string tag, logic [1:0] b, logic [1:0] inf);
    block_in = b;
    axis_info_in = inf;
    rpt_ready = 1;
    push(b, inf, cyc + P - 1);
    for (int i = 0; i < P; i++) begin
      chk({tag, "_pre"}, rpt_valid, 0);
      tick();
    end
    chk({tag, "_valid"}, rpt_valid, 1);
    pop_check(tag);
    chk({tag, "_cnt"}, count, exp_cnt);
    chk({tag, "_sticky"}, sticky, 1);
    tick();
    block_in = '0;
    chk({tag, "_hs"}, rpt_valid, 0);
    tick();
  endtask

  initial begin
    tick(3);
    reset = 0;
    chk("rst_valid", rpt_valid, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_cnt", count, 0);
    chk("rst_ts", rpt_ts, 0);
    chk("rst_mon", rpt_mon, 0);
    chk("rst_info", rpt_info, 0);
    chk("rst_tsq", dut.ts_q, 0);
    block_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      chk("short_valid", rpt_valid, 0);
      tick();
    end
    block_in = '0;
    for (int i = 0; i < 4; i++) begin
      chk("short_valid", rpt_valid, 0);
      tick();
    end
    chk("short_cnt", count, 0);
    chk("short_sticky", sticky, 0);
    while (cyc < 10) tick();
    axis_info_in = 2'b10;
    rpt_ready = 1;
    block_in = 2'b11;
    push(2'b11, 2'b10, cyc + P - 1);
    for (int i = 0; i < P; i++) begin
      chk("lat_pre", rpt_valid, 0);
      tick();
    end
    chk("lat_valid", rpt_valid, 1);
    chk("lat_ts13", rpt_ts, 13);
    pop_check("lat");
    chk("lat_cnt", count, 1);
    chk("lat_sticky", sticky, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("once_valid", rpt_valid, 0);
    end
    rpt_ready = 0;
    block_in = '0;
    tick();
    block_in = 2'b10;
    axis_info_in = 2'b10;
    push(2'b10, 2'b10, cyc + P - 1);
    tick(P);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", rpt_valid, 1);
      chk("bp_ts", rpt_ts, q[0].ts);
      chk("bp_mon", rpt_mon, q[0].mon);
      chk("bp_info", rpt_info, q[0].info);
      block_in = 2'($urandom);
      axis_info_in = 2'($urandom);
      tick();
    end
    rpt_ready = 1;
    block_in = '0;
    chk("bp_valid_end", rpt_valid, 1);
    pop_check("bp");
    tick();
    chk("bp_hs", rpt_valid, 0);
    chk("bp_cnt", count, exp_cnt);
    tick();
    event_go("second", 2'b01, 2'b01);
    block_in = 2'b11;
    axis_info_in = 2'b00;
    tick(P - 1);
    clear = 1;
    chk("clr_conf_valid", rpt_valid, 0);
    tick();
    clear = 0;
    exp_cnt = 0;
    chk("clr_valid", rpt_valid, 0);
    chk("clr_cnt", count, 0);
    chk("clr_sticky", sticky, 0);
    chk("clr_keep_ts", rpt_ts, last.ts);
    chk("clr_keep_mon", rpt_mon, last.mon);
    chk("clr_keep_info", rpt_info, last.info);
    push(2'b11, 2'b00, cyc + P - 1);
    for (int i = 0; i < P; i++) begin
      chk("rearm_pre", rpt_valid, 0);
      tick();
    end
    chk("rearm_valid", rpt_valid, 1);
    pop_check("rearm");
    chk("rearm_cnt", count, 1);
    clear = 1;
    tick();
    clear = 0;
    exp_cnt = 0;
    chk("clrhs_valid", rpt_valid, 0);
    chk("clrhs_cnt", count, 0);
    chk("clrhs_sticky", sticky, 0);
    rpt_ready = 0;
    push(2'b11, 2'b00, cyc + P - 1);
    for (int i = 0; i < P; i++) begin
      chk("clrhs_pre", rpt_valid, 0);
      tick();
    end
    chk("clrhs_rep", rpt_valid, 1);
    pop_check("clrhs");
    reset = 1;
    tick();
    reset = 0;
    block_in = '0;
    exp_cnt = 0;
    chk("mrst_valid", rpt_valid, 0);
    chk("mrst_cnt", count, 0);
    chk("mrst_sticky", sticky, 0);
    chk("mrst_tsq", dut.ts_q, 0);
    chk("mrst_ts", rpt_ts, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_idle", rpt_valid, 0);
    end
    force dut.deadlock_count = 16'hFFFD;
    tick();
    release dut.deadlock_count;
    exp_cnt = 65533;
    event_go("sat1", 2'b10, 2'b10);
    event_go("sat2", 2'b01, 2'b00);
    event_go("sat3", 2'b11, 2'b01);
    chk("sat_hold", count, 16'hFFFF);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
